switch_poll_ctrl: RTL

SWITCH_POLL_CTRL -- requirements
Module: switch_poll_ctrl

---
 rtl/switch_poll_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/switch_poll_ctrl.sv
// Switch poll controller: periodically reads a PIO through a one-cycle-latency
// read port, debounces the sampled switch vector, and exposes STABLE, EDGE,
// MASK and PERIOD registers to a CPU. irq is a level interrupt for masked edges.
// Optional feature macro: SWITCH_POLL_CTRL_IRQ_EN (MASK register and irq).
module switch_poll_ctrl #(
  parameter int unsigned WIDTH        = 17,
  parameter int unsigned POLL_DIV     = 50000,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [1:0]  m_address,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  input  logic [1:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        irq
);

  localparam logic [31:0] PollDivW = 32'(POLL_DIV);
  localparam logic [3:0]  DebMax   = 4'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {StIdle, StReq, StCapt, StEval} state_e;

  state_e           state_q, state_d;
  logic [31:0]      per_cnt_q, per_cnt_d;
  logic [31:0]      period_q, period_d;
  logic [3:0]       deb_q, deb_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] sample_q, sample_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] mask_val;
  logic [31:0]      rdata_q, rdata_d;

  logic wr_edge, wr_mask, wr_period;
  logic unused_rd;

  assign wr_edge   = s_write && (s_address == 2'd1);
  assign wr_mask   = s_write && (s_address == 2'd2);
  assign wr_period = s_write && (s_address == 2'd3);

  // Only the switch bits of the PIO word matter.
  assign unused_rd = ^m_readdata[31:WIDTH];

  assign m_read     = (state_q == StReq);
  assign m_address  = 2'd0;
  assign s_readdata = rdata_q;

  // Poll sequencer and period counter. The counter keeps running through
  // REQ/CAPT/EVAL so that REQ recurs every PERIOD cycles (for PERIOD >= 4).
  always_comb begin
    state_d   = state_q;
    per_cnt_d = per_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (period_q != 32'd0) begin
          if (per_cnt_q <= 32'd1) begin
            state_d   = StReq;
            per_cnt_d = period_q;
          end else begin
            per_cnt_d = per_cnt_q - 32'd1;
          end
        end
      end
      StReq: begin
        state_d   = StCapt;
        per_cnt_d = (per_cnt_q > 32'd1) ? per_cnt_q - 32'd1 : per_cnt_q;
      end
      StCapt: begin
        state_d   = StEval;
        per_cnt_d = (per_cnt_q > 32'd1) ? per_cnt_q - 32'd1 : per_cnt_q;
      end
      StEval: begin
        state_d   = StIdle;
        per_cnt_d = (per_cnt_q > 32'd1) ? per_cnt_q - 32'd1 : per_cnt_q;
      end
    endcase
    // A PERIOD write restarts the countdown without disturbing the poll.
    if (wr_period) per_cnt_d = s_writedata;
    period_d = wr_period ? s_writedata : period_q;
  end

  // Sample capture, debounce, stable update and edge accumulation.
  always_comb begin
    sample_d = sample_q;
    cand_d   = cand_q;
    deb_d    = deb_q;
    stable_d = stable_q;
    edge_set = '0;
    if (state_q == StCapt) sample_d = m_readdata[WIDTH-1:0];
    if (state_q == StEval) begin
      if (sample_q != cand_q) begin
        cand_d = sample_q;
        deb_d  = 4'd1;
      end else if (deb_q < DebMax) begin
        deb_d = deb_q + 4'd1;
      end
      if ((deb_d == DebMax) && (cand_d != stable_q)) begin
        stable_d = cand_d;
        edge_set = stable_q ^ cand_d;
      end
    end
    // Clear first, then set, so a simultaneous new edge survives the W1C.
    edge_d = (edge_q & ~(wr_edge ? s_writedata[WIDTH-1:0] : '0)) | edge_set;
  end

  // CPU read mux; the output register only moves on a read strobe.
  always_comb begin
    rdata_d = rdata_q;
    if (s_read) begin
      rdata_d = '0;
      unique case (s_address)
        2'd0: rdata_d[WIDTH-1:0] = stable_q;
        2'd1: rdata_d[WIDTH-1:0] = edge_q;
        2'd2: rdata_d[WIDTH-1:0] = mask_val;
        2'd3: rdata_d = period_q;
      endcase
    end
  end

  // Core state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      per_cnt_q <= PollDivW;
      period_q  <= PollDivW;
      deb_q     <= '0;
      cand_q    <= '0;
      sample_q  <= '0;
      stable_q  <= '0;
      edge_q    <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      per_cnt_q <= per_cnt_d;
      period_q  <= period_d;
      deb_q     <= deb_d;
      cand_q    <= cand_d;
      sample_q  <= sample_d;
      stable_q  <= stable_d;
      edge_q    <= edge_d;
      rdata_q   <= rdata_d;
    end
  end

`ifdef SWITCH_POLL_CTRL_IRQ_EN
  logic [WIDTH-1:0] mask_q;
  logic             irq_q;

  assign mask_val = mask_q;
  assign irq      = irq_q;

  // Interrupt mask and registered interrupt level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_mask) mask_q <= s_writedata[WIDTH-1:0];
      irq_q <= |(edge_q & mask_q);
    end
  end
`else
  logic unused_mask;

  assign mask_val    = '0;
  assign irq         = 1'b0;
  assign unused_mask = wr_mask;
`endif

endmodule
